act_buffer_pp: RTL
==================

# act_buffer_pp

Ping-pong double-buffered activation store between the activation DMA write port and the systolic-array activation reader. Two banks of DEPTH 64-bit words: the DMA fills one bank while the array reads the other, so the next tile's activations load during compute. Bank ownership moves by explicit commit (DMA side) and release (array side) pulses. No AXI logic lives here.

## Interface
- DATA_W, 64, word width; matches DMA beat width
- DEPTH, 1024, words per bank; power of two
- ADDR_W, 32, width of incoming DMA word address
- IDX_W, $clog2(DEPTH), bank index width

- clk  in  1  sole clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- wr_we  in  1  DMA word write strobe
- wr_addr  in  ADDR_W  word index within fill bank, 0-based
- wr_data  in  DATA_W  write data
- wr_commit  in  1  pulse: fill bank complete (DMA done, no error)
- wr_abort  in  1  pulse: discard fill bank contents (DMA error)
- wr_ready  out  1  fill bank free to accept writes
- rd_en  in  1  array read request
- rd_addr  in  IDX_W  word index within read bank
- rd_data  out  DATA_W  read data, 1-cycle latency
- rd_valid  out  1  rd_data valid this cycle
- rd_release  in  1  pulse: array finished with read bank
- rd_bank_valid  out  1  read bank holds committed data
- rd_count  out  IDX_W+1  committed word count of read bank
- fill_bank  out  1  bank index currently filling
- read_bank  out  1  bank index currently readable
- overflow_err  out  1  sticky write-drop flag
- err_clr  in  1  clears overflow_err

## Operation
- State: full[1:0], wr_ptr, rd_ptr, fill_cnt (IDX_W+1), cnt[0..1] (IDX_W+1 each). All decisions use pre-edge state.
- Reset: full=0, wr_ptr=rd_ptr=0, fill_cnt=0, cnt=0, rd_valid=0, rd_data=0, overflow_err=0. Memory contents not reset.
- wr_ready = !full[wr_ptr]; fill_bank = wr_ptr; read_bank = rd_ptr; rd_bank_valid = full[rd_ptr]; rd_count = full[rd_ptr] ? cnt[rd_ptr] : 0.
- Write: wr_we with wr_ready and wr_addr < DEPTH -> mem[wr_ptr][wr_addr] = wr_data; fill_cnt = max(fill_cnt, wr_addr+1). Compare full ADDR_W width, no truncation.
- Dropped write (wr_we with !wr_ready, or wr_addr >= DEPTH): memory and fill_cnt untouched; overflow_err set.
- overflow_err: err_clr clears; set wins over clear in same cycle.
- Commit: wr_commit with wr_ready and (fill_cnt != 0 or same-cycle accepted write) -> cnt[wr_ptr] = final fill count, full[wr_ptr]=1, wr_ptr toggles, fill_cnt=0. Commit with zero words or !wr_ready is ignored.
- wr_we + wr_commit same cycle: write lands in committing bank and is counted.
- wr_abort: fill_cnt=0, no toggle. Abort beats commit; same-cycle write is also discarded.
- Read: rd_en with full[rd_ptr] -> next cycle rd_valid=1, rd_data = mem[rd_ptr][rd_addr] if rd_addr < cnt[rd_ptr], else 0. rd_en with !full[rd_ptr]: rd_valid=0, rd_data holds.
- Release: rd_release with full[rd_ptr] -> full[rd_ptr]=0, rd_ptr toggles; otherwise ignored.
- rd_en + rd_release same cycle: read served from pre-release bank.
- Commit + release same cycle: both apply. When wr_ptr==rd_ptr with both banks empty, the release is ignored and the commit lands.

## Timing
- Write to memory: same edge as wr_we. Data readable one cycle after its commit edge.
- Read latency: exactly 1 cycle, rd_en -> rd_valid/rd_data; one read per cycle sustained.
- wr_ready, rd_bank_valid, rd_count reflect commit/release on the following cycle.
- No combinational path from any input to any output except the listed pointer/full decodes (registered sources only).
- Throughput: one write and one read per cycle concurrently, on different banks.

## Test plan
- Reset, write words 0..15 (data=0x100+i), commit -> next cycle rd_bank_valid=1, rd_count=16, wr_ready=1, fill_bank=1; read addr 5 -> rd_data=0x105 one cycle later.
- Fill and commit both banks -> wr_ready=0; wr_we at addr 0 -> dropped, overflow_err=1; err_clr -> 0; release -> wr_ready=1, read_bank=1.
- Write addr 3 only, commit -> rd_count=4; read addr 9 -> rd_data=0, rd_valid=1. Write addr DEPTH -> overflow_err=1, count unchanged.
- Write 8 words, wr_abort with a same-cycle commit -> no flip, rd_bank_valid stays 0; commit with zero writes -> ignored.
- Concurrent: bank 1 streaming 16 writes while array reads bank 0 every cycle; commit and release on the same edge -> rd_ptr=1, wr_ptr=0, rd_count=16, no data corruption.
- Assert rst mid-fill with one bank full -> all outputs at reset values next cycle, rd_bank_valid=0, wr_ready=1.

Source files
------------

// File: rtl/act_buffer_pp.sv
// rtl/act_buffer_pp.sv - ping-pong activation buffer between DMA fill port and array reader
module act_buffer_pp #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  input  logic              wr_abort,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_release,
  output logic              rd_bank_valid,
  output logic [IDX_W:0]    rd_count,
  output logic              fill_bank,
  output logic              read_bank,
  output logic              overflow_err,
  input  logic              err_clr
);

  logic [1:0]        full;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [IDX_W:0]    fill_cnt;
  logic [IDX_W:0]    cnt [2];
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic              addr_ok;
  logic              wr_acc;
  logic              wr_drop;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W:0]    wr_end;
  logic [IDX_W:0]    fill_nxt;
  logic              commit_ok;
  logic              release_ok;
  logic              rd_hit;

  // Address check spans the full DMA address so high bits never alias into the bank.
  assign addr_ok    = wr_addr < ADDR_W'(DEPTH);
  assign wr_acc     = wr_we && wr_ready && addr_ok && !wr_abort;
  assign wr_drop    = wr_we && !(wr_ready && addr_ok);
  assign wr_idx     = wr_addr[IDX_W-1:0];
  assign wr_end     = {1'b0, wr_idx} + (IDX_W+1)'(1);
  assign fill_nxt   = (wr_acc && (wr_end > fill_cnt)) ? wr_end : fill_cnt;
  assign commit_ok  = wr_commit && wr_ready && !wr_abort && (fill_nxt != '0);
  assign release_ok = rd_release && full[rd_ptr];
  assign rd_hit     = {1'b0, rd_addr} < cnt[rd_ptr];

  assign wr_ready      = !full[wr_ptr];
  assign fill_bank     = wr_ptr;
  assign read_bank     = rd_ptr;
  assign rd_bank_valid = full[rd_ptr];
  assign rd_count      = full[rd_ptr] ? cnt[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[{wr_ptr, wr_idx}] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full         <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fill_cnt     <= '0;
      cnt[0]       <= '0;
      cnt[1]       <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_abort) begin
        fill_cnt <= '0;
      end else if (commit_ok) begin
        cnt[wr_ptr] <= fill_nxt;
        fill_cnt    <= '0;
        wr_ptr      <= ~wr_ptr;
      end else begin
        fill_cnt <= fill_nxt;
      end

      // Commit needs an empty bank and release a full one, so they never touch the same bit.
      if (release_ok) begin
        full[rd_ptr] <= 1'b0;
        rd_ptr       <= ~rd_ptr;
      end
      if (commit_ok) begin
        full[wr_ptr] <= 1'b1;
      end

      if (wr_drop) begin
        overflow_err <= 1'b1;
      end else if (err_clr) begin
        overflow_err <= 1'b0;
      end

      if (rd_en && full[rd_ptr]) begin
        rd_valid <= 1'b1;
        rd_data  <= rd_hit ? mem[{rd_ptr, rd_addr}] : '0;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
